// File: rtl/expr_eval_ctrl_if.sv
// Character-in / result-out handshake bundle for expr_eval_ctrl.
// The master drives characters and consumes results; the slave is the controller.
interface expr_eval_ctrl_if #(
  parameter int unsigned W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/expr_eval_ctrl.sv
// Streaming '+'/'*' expression evaluator with '*' precedence; one result per '='.
// Define EXPR_MULTIDIGIT_EN to accept multi-digit decimal operands.
module expr_eval_ctrl #(
  parameter int unsigned W = 16
) (
  input  logic               clk,
  input  logic               clr,
  expr_eval_ctrl_if.slave    bus,
  output logic               busy
);

  typedef enum logic [2:0] {StStart, StNum, StOp, StErr, StDone} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic [W-1:0] num_q, num_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic         res_err_q, res_err_d;
  logic         busy_q, busy_d;

  logic         xfer;
  logic         is_space, is_digit, is_plus, is_mul, is_eq;
  logic [W-1:0] digit;
  logic [W-1:0] prod;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign is_space = bus.in_data == 8'h20;
  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign is_plus  = bus.in_data == 8'h2b;
  assign is_mul   = bus.in_data == 8'h2a;
  assign is_eq    = bus.in_data == 8'h3d;
  // Low nibble of an ASCII digit is its value.
  assign digit    = W'(bus.in_data[3:0]);
  assign prod     = term_q * num_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StStart;
      sum_q      <= '0;
      term_q     <= W'(1);
      num_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      term_q     <= term_d;
      num_q      <= num_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    term_d     = term_q;
    num_d      = num_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    busy_d     = busy_q;

    if (state_q == StDone) begin
      if (bus.res_ready) begin
        state_d    = StStart;
        sum_d      = '0;
        term_d     = W'(1);
        num_d      = '0;
        res_data_d = '0;
        res_err_d  = 1'b0;
        busy_d     = 1'b0;
      end
    end else if (xfer && !is_space) begin
      busy_d = 1'b1;
      if (is_digit) begin
        unique case (state_q)
          StStart, StOp: begin
            state_d = StNum;
            num_d   = digit;
          end
          StNum: begin
`ifdef EXPR_MULTIDIGIT_EN
            num_d = num_q * W'(10) + digit;
`else
            state_d = StErr;
`endif
          end
          default: ;
        endcase
      end else if (is_plus || is_mul) begin
        if (state_q == StNum) begin
          state_d = StOp;
          if (is_plus) begin
            sum_d  = sum_q + prod;
            term_d = W'(1);
          end else begin
            term_d = prod;
          end
        end else begin
          state_d = StErr;
        end
      end else if (is_eq) begin
        state_d = StDone;
        if (state_q == StNum) begin
          res_data_d = sum_q + prod;
          res_err_d  = 1'b0;
        end else begin
          res_data_d = '0;
          res_err_d  = 1'b1;
        end
      end else begin
        state_d = StErr;
      end
    end
  end

  assign bus.in_ready  = state_q != StDone;
  assign bus.res_valid = state_q == StDone;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign busy          = busy_q;

endmodule
